// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: conditions four raw car-detector inputs into clean traffic
// flags (Ta, Tal, Tb, Tbl) for the traffic-light next-state logic.
// Each channel is synchronised, then debounced. A new level is accepted only
// after DB_CNT consecutive qualifying ticks that all disagree with the current
// output. chg pulses for one cycle on the edge after any flag has changed.
module tl_sensor_cond #(
    parameter int DB_CNT = 4,
    parameter int CNT_W  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic Ta_raw,
    input  logic Tal_raw,
    input  logic Tb_raw,
    input  logic Tbl_raw,
    output logic Ta,
    output logic Tal,
    output logic Tb,
    output logic Tbl,
    output logic chg
);

    localparam int NCH = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel order in every vector: bit 0 = Ta, 1 = Tal, 2 = Tb, 3 = Tbl.
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   o_q;
    logic [NCH-1:0]   o_d;
    logic [NCH-1:0]   o_prev_q;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             chg_q;

    assign raw = {Tbl_raw, Tb_raw, Tal_raw, Ta_raw};

    // Two-flop synchronizer for the asynchronous detector inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Debounce next state: any return of s2 to o restarts qualification.
    always_comb begin
        o_d = o_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == o_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_MAX) begin
                    o_d[i]   = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounce counters and conditioned flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            o_q <= o_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Change pulse: compares the flags against their value one edge earlier,
    // so a flag updated on edge N yields chg high after edge N+1 only.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_prev_q <= '0;
            chg_q    <= 1'b0;
        end else begin
            o_prev_q <= o_q;
            chg_q    <= |(o_q ^ o_prev_q);
        end
    end

    assign Ta  = o_q[0];
    assign Tal = o_q[1];
    assign Tb  = o_q[2];
    assign Tbl = o_q[3];
    assign chg = chg_q;

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Scoreboard bench for tl_sensor_cond: one instance with DB_CNT=4 and one with
// DB_CNT=1 share the same stimulus. A behavioural model written from the
// channel rules pushes the expected outputs; a monitor pops and compares.
module tb_tl_sensor_cond;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic Ta_raw = 1'b0, Tal_raw = 1'b0, Tb_raw = 1'b0, Tbl_raw = 1'b0;
    logic Ta4, Tal4, Tb4, Tbl4, chg4;
    logic Ta1, Tal1, Tb1, Tbl1, chg1;

    always #5 clk = ~clk;

    tl_sensor_cond #(.DB_CNT(4), .CNT_W(3)) u_db4 (
        .clk(clk), .reset(reset), .tick(tick),
        .Ta_raw(Ta_raw), .Tal_raw(Tal_raw), .Tb_raw(Tb_raw), .Tbl_raw(Tbl_raw),
        .Ta(Ta4), .Tal(Tal4), .Tb(Tb4), .Tbl(Tbl4), .chg(chg4)
    );

    tl_sensor_cond #(.DB_CNT(1), .CNT_W(1)) u_db1 (
        .clk(clk), .reset(reset), .tick(tick),
        .Ta_raw(Ta_raw), .Tal_raw(Tal_raw), .Tb_raw(Tb_raw), .Tbl_raw(Tbl_raw),
        .Ta(Ta1), .Tal(Tal1), .Tb(Tb1), .Tbl(Tbl1), .chg(chg1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];

    // Reference model, index 0 = DB_CNT 4, index 1 = DB_CNT 1.
    // pipe1/pipe2: raw level as seen one and two edges after sampling.
    // streak: number of ticks seen so far in the current disagreement.
    int       db_len [2] = '{4, 1};
    bit [3:0] pipe1 [2];
    bit [3:0] pipe2 [2];
    bit [3:0] flag  [2];
    bit [3:0] flag_before [2];
    int       streak [2][4];
    bit       pulse [2];

    task automatic model_edge(input bit rst, input bit tk, input bit [3:0] r);
        bit [3:0] old_flag;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                pipe1[m] = '0; pipe2[m] = '0; flag[m] = '0;
                flag_before[m] = '0; pulse[m] = 1'b0;
                for (int c = 0; c < 4; c++) streak[m][c] = 0;
            end else begin
                old_flag = flag[m];
                for (int c = 0; c < 4; c++) begin
                    if (pipe2[m][c] == old_flag[c]) begin
                        streak[m][c] = 0;
                    end else if (tk) begin
                        streak[m][c] = streak[m][c] + 1;
                        if (streak[m][c] == db_len[m]) begin
                            flag[m][c] = pipe2[m][c];
                            streak[m][c] = 0;
                        end
                    end
                end
                pulse[m]       = (old_flag != flag_before[m]);
                flag_before[m] = old_flag;
                pipe2[m]       = pipe1[m];
                pipe1[m]       = r;
            end
        end
    endtask

    task automatic step(input bit rst, input bit tk, input bit [3:0] r);
        @(negedge clk);
        reset = rst;
        tick  = tk;
        {Tbl_raw, Tb_raw, Tal_raw, Ta_raw} = r;
        model_edge(rst, tk, r);
        exp_q.push_back({pulse[1], flag[1], pulse[0], flag[0]});
    endtask

    // Monitor: outputs are presented every cycle, so each edge with a pending
    // expectation is compared.
    initial begin
        logic [9:0] e;
        logic [4:0] a4, a1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                a4 = {chg4, Tbl4, Tb4, Tal4, Ta4};
                a1 = {chg1, Tbl1, Tb1, Tal1, Ta1};
                n_checks++;
                if (a4 !== e[4:0]) begin
                    n_fail++;
                    $display("FAIL db4_chg_Tbl_Tb_Tal_Ta at %0t: got %b want %b", $time, a4, e[4:0]);
                end
                n_checks++;
                if (a1 !== e[9:5]) begin
                    n_fail++;
                    $display("FAIL db1_chg_Tbl_Tb_Tal_Ta at %0t: got %b want %b", $time, a1, e[9:5]);
                end
            end
        end
    end

    initial begin
        bit [3:0] r;
        bit rs, tk;
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000);
        // Basic accept on Ta, then hold long enough to see the chg pulse
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b0001);
        // Glitch on Tb for 3 clocks, then back to 0
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0101);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b0001);
        // Tick only every third cycle, Tal rises
        for (int i = 0; i < 36; i++) step(1'b0, (i % 3) == 2, 4'b0011);
        // Release path on Ta
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b0010);
        // Ta and Tbl rise together
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b1011);
        // Clear everything, then Tb rises and reset hits mid-qualification
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0100);
        step(1'b1, 1'b1, 4'b0100);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b0100);
        // Randomised traffic: sparse raw flips, random tick, rare resets
        r = 4'b0100;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 9) == 0) r[c] = ~r[c];
            end
            tk = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 399) == 0);
            step(rs, tk, r);
        end
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_sensor_cond.md
TL_SENSOR_COND -- requirements
Module: tl_sensor_cond

Purpose: upstream stage of the next-state logic; conditions raw car-detector inputs into clean Ta, Tal, Tb, Tbl traffic flags.

Interface
REQ-001 Parameters SHALL be, one per line:
  DB_CNT, 4, consecutive qualifying ticks needed to accept a new level (legal range 1..2^CNT_W)
  CNT_W, 3, debounce counter width in bits
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all flops update on the rising edge
  reset  input  1  synchronous, active-high reset
  tick  input  1  debounce sample enable; may be tied high
  Ta_raw  input  1  raw main-road straight sensor, asynchronous to clk
  Tal_raw  input  1  raw main-road left-turn sensor, asynchronous to clk
  Tb_raw  input  1  raw side-road straight sensor, asynchronous to clk
  Tbl_raw  input  1  raw side-road left-turn sensor, asynchronous to clk
  Ta  output  1  conditioned main-road straight flag, registered
  Tal  output  1  conditioned main-road left flag, registered
  Tb  output  1  conditioned side-road straight flag, registered
  Tbl  output  1  conditioned side-road left flag, registered
  chg  output  1  one-cycle pulse when any conditioned flag changes
REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Each of the four channels SHALL be an identical, independent instance of the logic in REQ-005 to REQ-010; no channel SHALL affect another.
REQ-005 Each raw input SHALL pass through a 2-flop synchronizer (s1, then s2) before any other logic uses it.
REQ-006 Each channel SHALL hold a CNT_W-bit counter cnt and a registered output o.
REQ-007 When s2 == o, cnt SHALL clear to 0 on the next edge, regardless of tick.
REQ-008 When s2 != o and tick == 0, cnt and o SHALL hold.
REQ-009 When s2 != o, tick == 1 and cnt < DB_CNT-1, cnt SHALL increment by 1.
REQ-010 When s2 != o, tick == 1 and cnt == DB_CNT-1, o SHALL take the value of s2 and cnt SHALL clear to 0 on the same edge.
REQ-011 A glitch shorter than the accept window SHALL never reach an output; any return of s2 to o SHALL restart qualification from 0.
REQ-012 Latency with tick held high: a raw level that is stable before edge 1 SHALL appear on its output after edge DB_CNT+2 (edge 6 for DB_CNT=4).
REQ-013 With DB_CNT=1, an output SHALL follow s2 one edge after s2 changes.
REQ-014 chg SHALL be registered and SHALL be 1 for exactly the cycle after any edge on which at least one o changed, including when several channels change on the same edge; otherwise chg SHALL be 0.
REQ-015 cnt SHALL never exceed DB_CNT-1 and SHALL never wrap.

Reset
REQ-016 While reset is 1 at an edge: all synchronizer flops, all cnt, Ta, Tal, Tb, Tbl and chg SHALL be 0.
REQ-017 A reset asserted mid-qualification SHALL discard the partial count, and no output change SHALL result from it.
REQ-018 After reset is released, a raw input already at 1 SHALL be treated as a new level and SHALL follow REQ-012 timing measured from the first edge after release.

Verification
REQ-019 Basic accept: DB_CNT=4, tick=1, Ta_raw 0->1 before edge 1 -> Ta=1 after edge 6, chg=1 after edge 7 only, other outputs remain 0.
REQ-020 Glitch reject: Tb_raw=1 for 3 clks, then 0 -> Tb stays 0 and cnt returns to 0.
REQ-021 Tick gating: tick high on every 3rd cycle, Tal_raw 0->1 -> Tal rises on the 4th qualifying tick after s2=1, not before.
REQ-022 Simultaneous: Ta_raw and Tbl_raw rise on the same cycle -> both flags rise on the same edge and chg is a single 1-cycle pulse.
REQ-023 Reset mid-operation: Tb_raw=1, reset pulsed at cnt=2 -> all outputs and counts are 0; Tb rises 6 edges after reset release.
REQ-024 Release path: Ta=1, Ta_raw 1->0 -> Ta falls after edge 6 with chg pulse; also run DB_CNT=1 and check REQ-013 timing.
